// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Memory-access stage. Accepts one load/store request at a time,
//               runs a single Wishbone-style data-bus cycle and returns
//               aligned, sign/zero-extended load data or an error strobe.
//               Misaligned or illegal-size requests are rejected without a
//               bus cycle. A watchdog aborts bus cycles that never complete.
// Ports       : clk_i, rst_i            clock / async active-high reset
//               req_*                   request handshake and fields
//               resp_*                  one-cycle response to writeback
//               mem_*                   data-bus master interface
// Revision    : 1.0  initial release
// ============================================================================
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 64   // cycles in BUS before abort; 0 = never
) (
    input  logic        clk_i,
    input  logic        rst_i,
    // request
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    // response
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        resp_misalign_o,
    // data bus
    output logic        mem_cyc_o,
    output logic        mem_stb_o,
    output logic        mem_we_o,
    output logic [31:0] mem_adr_o,
    output logic [3:0]  mem_sel_o,
    output logic [31:0] mem_dat_o,
    input  logic [31:0] mem_dat_i,
    input  logic        mem_ack_i,
    input  logic        mem_err_i
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // Counter value seen in the last permitted BUS cycle: the counter is 0 in
    // the first BUS cycle, so the abort fires on the TIMEOUT_CYCLES-th cycle.
    localparam logic [CNT_W-1:0] C_TIMEOUT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    localparam logic [1:0] C_SIZE_BYTE = 2'b00;
    localparam logic [1:0] C_SIZE_HALF = 2'b01;
    localparam logic [1:0] C_SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             state_q,        state_d;
    logic [CNT_W-1:0]   timeout_cnt_q,  timeout_cnt_d;
    logic [1:0]         size_q,         size_d;
    logic               unsigned_q,     unsigned_d;
    logic [1:0]         addr_lo_q,      addr_lo_d;
    logic               stb_q,          stb_d;
    logic               we_q,           we_d;
    logic [31:0]        adr_q,          adr_d;
    logic [3:0]         sel_q,          sel_d;
    logic [31:0]        dat_q,          dat_d;
    logic               resp_valid_q,   resp_valid_d;
    logic [31:0]        resp_rdata_q,   resp_rdata_d;
    logic               resp_err_q,     resp_err_d;
    logic               resp_misalign_q, resp_misalign_d;

    logic               w_accept;
    logic               w_misalign;
    logic               w_timeout;
    logic [3:0]         w_sel;
    logic [31:0]        w_wdata;
    logic [31:0]        w_shifted;
    logic [31:0]        w_load_data;

    assign w_accept = req_valid_i && (state_q == S_IDLE);

    // Request decode, evaluated on the raw inputs so the accept edge can load
    // the bus registers directly.
    always_comb begin
        w_misalign = 1'b0;
        w_sel      = 4'b0000;
        w_wdata    = req_wdata_i;
        case (req_size_i)
            C_SIZE_BYTE: begin
                w_sel   = 4'b0001 << req_addr_i[1:0];
                w_wdata = {4{req_wdata_i[7:0]}};
            end
            C_SIZE_HALF: begin
                w_misalign = req_addr_i[0];
                w_sel      = 4'b0011 << {req_addr_i[1], 1'b0};
                w_wdata    = {2{req_wdata_i[15:0]}};
            end
            C_SIZE_WORD: begin
                w_misalign = (req_addr_i[1:0] != 2'b00);
                w_sel      = 4'b1111;
                w_wdata    = req_wdata_i;
            end
            default: begin
                w_misalign = 1'b1;
            end
        endcase
    end

    assign w_timeout = (TIMEOUT_CYCLES > 0) && (timeout_cnt_q == C_TIMEOUT_LAST);

    // Right-justify the addressed lane, then extend according to size.
    assign w_shifted = mem_dat_i >> {addr_lo_q, 3'b000};

    always_comb begin
        w_load_data = 32'h0;
        case (size_q)
            C_SIZE_BYTE: w_load_data = unsigned_q ? {24'h0, w_shifted[7:0]}
                                                  : {{24{w_shifted[7]}}, w_shifted[7:0]};
            C_SIZE_HALF: w_load_data = unsigned_q ? {16'h0, w_shifted[15:0]}
                                                  : {{16{w_shifted[15]}}, w_shifted[15:0]};
            C_SIZE_WORD: w_load_data = w_shifted;
            default:     w_load_data = 32'h0;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d         = state_q;
        timeout_cnt_d   = timeout_cnt_q;
        size_d          = size_q;
        unsigned_d      = unsigned_q;
        addr_lo_d       = addr_lo_q;
        stb_d           = stb_q;
        we_d            = we_q;
        adr_d           = adr_q;
        sel_d           = sel_q;
        dat_d           = dat_q;
        resp_valid_d    = 1'b0;
        resp_rdata_d    = 32'h0;
        resp_err_d      = 1'b0;
        resp_misalign_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    size_d     = req_size_i;
                    unsigned_d = req_unsigned_i;
                    addr_lo_d  = req_addr_i[1:0];
                    if (w_misalign) begin
                        state_d         = S_RESP;
                        resp_valid_d    = 1'b1;
                        resp_err_d      = 1'b1;
                        resp_misalign_d = 1'b1;
                    end else begin
                        state_d       = S_BUS;
                        timeout_cnt_d = '0;
                        stb_d         = 1'b1;
                        we_d          = req_we_i;
                        adr_d         = {req_addr_i[31:2], 2'b00};
                        sel_d         = w_sel;
                        dat_d         = w_wdata;
                    end
                end
            end

            S_BUS: begin
                if (mem_err_i || mem_ack_i || w_timeout) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    stb_d        = 1'b0;
                    we_d         = 1'b0;
                    adr_d        = 32'h0;
                    sel_d        = 4'b0000;
                    dat_d        = 32'h0;
                    // Error takes priority over a simultaneous ack.
                    if (mem_err_i || !mem_ack_i) begin
                        resp_err_d = 1'b1;
                    end else if (!we_q) begin
                        resp_rdata_d = w_load_data;
                    end
                end else begin
                    timeout_cnt_d = timeout_cnt_q + CNT_W'(1);
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= S_IDLE;
            timeout_cnt_q   <= '0;
            size_q          <= 2'b00;
            unsigned_q      <= 1'b0;
            addr_lo_q       <= 2'b00;
            stb_q           <= 1'b0;
            we_q            <= 1'b0;
            adr_q           <= 32'h0;
            sel_q           <= 4'b0000;
            dat_q           <= 32'h0;
            resp_valid_q    <= 1'b0;
            resp_rdata_q    <= 32'h0;
            resp_err_q      <= 1'b0;
            resp_misalign_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            timeout_cnt_q   <= timeout_cnt_d;
            size_q          <= size_d;
            unsigned_q      <= unsigned_d;
            addr_lo_q       <= addr_lo_d;
            stb_q           <= stb_d;
            we_q            <= we_d;
            adr_q           <= adr_d;
            sel_q           <= sel_d;
            dat_q           <= dat_d;
            resp_valid_q    <= resp_valid_d;
            resp_rdata_q    <= resp_rdata_d;
            resp_err_q      <= resp_err_d;
            resp_misalign_q <= resp_misalign_d;
        end
    end

    assign req_ready_o     = (state_q == S_IDLE);
    assign resp_valid_o    = resp_valid_q;
    assign resp_rdata_o    = resp_rdata_q;
    assign resp_err_o      = resp_err_q;
    assign resp_misalign_o = resp_misalign_q;
    assign mem_cyc_o       = stb_q;
    assign mem_stb_o       = stb_q;
    assign mem_we_o        = we_q;
    assign mem_adr_o       = adr_q;
    assign mem_sel_o       = sel_q;
    assign mem_dat_o       = dat_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Directed self-checking bench for load_store_unit. Inputs are
//               driven 1 time unit after the rising edge and outputs are
//               checked at that point, well away from the next edge.
// Revision    : 1.0  initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err, resp_misalign;
    logic [31:0] resp_rdata;
    logic        mem_cyc, mem_stb, mem_we, mem_ack, mem_err;
    logic [31:0] mem_adr, mem_dat_o, mem_dat_i;
    logic [3:0]  mem_sel;

    int n_vec  = 0;
    int n_fail = 0;
    int stb_cycles;
    int guard;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_we_i        (req_we),
        .req_size_i      (req_size),
        .req_unsigned_i  (req_unsigned),
        .req_addr_i      (req_addr),
        .req_wdata_i     (req_wdata),
        .resp_valid_o    (resp_valid),
        .resp_rdata_o    (resp_rdata),
        .resp_err_o      (resp_err),
        .resp_misalign_o (resp_misalign),
        .mem_cyc_o       (mem_cyc),
        .mem_stb_o       (mem_stb),
        .mem_we_o        (mem_we),
        .mem_adr_o       (mem_adr),
        .mem_sel_o       (mem_sel),
        .mem_dat_o       (mem_dat_o),
        .mem_dat_i       (mem_dat_i),
        .mem_ack_i       (mem_ack),
        .mem_err_i       (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        tick();
        req_valid    = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        mem_dat_i = 32'h0; mem_ack = 1'b0; mem_err = 1'b0;
        tick(); tick();

        // ---- reset state
        check("rst_ready", {31'h0, req_ready}, 32'h1);
        check("rst_stb",   {31'h0, mem_stb},   32'h0);
        check("rst_resp",  {31'h0, resp_valid}, 32'h0);
        check("rst_adr",   mem_adr,            32'h0);
        rst = 1'b0;
        tick();

        // ---- LB 0x103, zero-wait ack
        request(1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0);
        check("lb_ready_drop", {31'h0, req_ready}, 32'h0);
        check("lb_stb",  {31'h0, mem_stb}, 32'h1);
        check("lb_cyc",  {31'h0, mem_cyc}, 32'h1);
        check("lb_sel",  {28'h0, mem_sel}, 32'h8);
        check("lb_adr",  mem_adr, 32'h0000_0100);
        check("lb_we",   {31'h0, mem_we}, 32'h0);
        mem_dat_i = 32'h80FF_FFFF; mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("lb_resp_valid", {31'h0, resp_valid}, 32'h1);
        check("lb_rdata", resp_rdata, 32'hFFFF_FF80);
        check("lb_err",   {31'h0, resp_err}, 32'h0);
        check("lb_stb_off", {31'h0, mem_stb}, 32'h0);
        check("lb_ready_resp", {31'h0, req_ready}, 32'h0);
        tick();
        check("lb_resp_clear", {31'h0, resp_valid}, 32'h0);
        check("lb_rdata_clear", resp_rdata, 32'h0);
        check("lb_ready_back", {31'h0, req_ready}, 32'h1);

        // ---- LHU 0x102
        request(1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0);
        check("lhu_sel", {28'h0, mem_sel}, 32'hC);
        mem_dat_i = 32'h9ABC_0000; mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("lhu_rdata", resp_rdata, 32'h0000_9ABC);
        tick();

        // ---- LH 0x102
        request(1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("lh_rdata", resp_rdata, 32'hFFFF_9ABC);
        tick();

        // ---- LBU 0x101 with one wait state
        request(1'b0, 2'b00, 1'b1, 32'h0000_0101, 32'h0);
        mem_dat_i = 32'h1122_C344;
        tick();
        check("lbu_wait_stb", {31'h0, mem_stb}, 32'h1);
        check("lbu_wait_noresp", {31'h0, resp_valid}, 32'h0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("lbu_rdata", resp_rdata, 32'h0000_00C3);
        tick();

        // ---- LW 0x104
        request(1'b0, 2'b10, 1'b0, 32'h0000_0104, 32'h0);
        check("lw_sel", {28'h0, mem_sel}, 32'hF);
        mem_dat_i = 32'hCAFE_F00D; mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("lw_rdata", resp_rdata, 32'hCAFE_F00D);
        tick();

        // ---- SB 0x201
        request(1'b1, 2'b00, 1'b0, 32'h0000_0201, 32'h1234_56A5);
        check("sb_sel", {28'h0, mem_sel}, 32'h2);
        check("sb_dat", mem_dat_o, 32'hA5A5_A5A5);
        check("sb_we",  {31'h0, mem_we}, 32'h1);
        check("sb_adr", mem_adr, 32'h0000_0200);
        mem_dat_i = 32'hFFFF_FFFF; mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("sb_resp_valid", {31'h0, resp_valid}, 32'h1);
        check("sb_rdata", resp_rdata, 32'h0);
        check("sb_we_off", {31'h0, mem_we}, 32'h0);
        tick();

        // ---- SH 0x402
        request(1'b1, 2'b01, 1'b0, 32'h0000_0402, 32'hDEAD_BEEF);
        check("sh_sel", {28'h0, mem_sel}, 32'hC);
        check("sh_dat", mem_dat_o, 32'hBEEF_BEEF);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();

        // ---- SW misaligned: no bus cycle, response next cycle
        request(1'b1, 2'b10, 1'b0, 32'h0000_0102, 32'h5555_5555);
        check("sw_mis_stb", {31'h0, mem_stb}, 32'h0);
        check("sw_mis_valid", {31'h0, resp_valid}, 32'h1);
        check("sw_mis_err", {31'h0, resp_err}, 32'h1);
        check("sw_mis_misalign", {31'h0, resp_misalign}, 32'h1);
        tick();
        check("sw_mis_stb2", {31'h0, mem_stb}, 32'h0);
        check("sw_mis_ready", {31'h0, req_ready}, 32'h1);

        // ---- illegal size 11
        request(1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'h0);
        check("ill_stb", {31'h0, mem_stb}, 32'h0);
        check("ill_err", {31'h0, resp_err}, 32'h1);
        check("ill_misalign", {31'h0, resp_misalign}, 32'h1);
        tick();

        // ---- ack outside BUS is ignored
        mem_ack = 1'b1; mem_err = 1'b1;
        tick();
        check("idle_ack_noresp", {31'h0, resp_valid}, 32'h0);
        mem_ack = 1'b0; mem_err = 1'b0;

        // ---- timeout with TIMEOUT_CYCLES=4
        request(1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0);
        stb_cycles = 0;
        guard = 0;
        while (!resp_valid && guard < 20) begin
            if (mem_stb) stb_cycles++;
            tick();
            guard++;
        end
        check("to_reached", {31'h0, resp_valid}, 32'h1);
        check("to_stb_cycles", stb_cycles, 32'd4);
        check("to_err", {31'h0, resp_err}, 32'h1);
        check("to_misalign", {31'h0, resp_misalign}, 32'h0);
        check("to_stb_off", {31'h0, mem_stb}, 32'h0);
        tick();

        // ---- ack and err together: err wins
        request(1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0);
        mem_dat_i = 32'h1234_5678; mem_ack = 1'b1; mem_err = 1'b1;
        tick();
        mem_ack = 1'b0; mem_err = 1'b0;
        check("ackerr_err", {31'h0, resp_err}, 32'h1);
        check("ackerr_rdata", resp_rdata, 32'h0);
        check("ackerr_misalign", {31'h0, resp_misalign}, 32'h0);
        tick();

        // ---- reset mid-BUS
        request(1'b0, 2'b10, 1'b0, 32'h0000_0500, 32'h0);
        check("rstmid_stb_before", {31'h0, mem_stb}, 32'h1);
        rst = 1'b1;
        #1;
        check("rstmid_stb_async", {31'h0, mem_stb}, 32'h0);
        check("rstmid_ready", {31'h0, req_ready}, 32'h1);
        tick();
        rst = 1'b0;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("rstmid_noresp1", {31'h0, resp_valid}, 32'h0);
        tick();
        check("rstmid_noresp2", {31'h0, resp_valid}, 32'h0);
        check("rstmid_ready2", {31'h0, req_ready}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
